// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default oversampling and the
// baud divider computation used by both the RX and TX sides.
`timescale 1ns / 1ps

package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Clocks per sample tick, truncated; never below 1 so the divider stays legal.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud * oversample);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running sample-tick divider: one s_tick every DIV clocks, restartable
// through a synchronous clear so ticks are phase-locked to the start edge.
`timescale 1ns / 1ps

module uart_rx_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic s_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..DIV-1 and restart; clear restarts the phase immediately.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign s_tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling. Synchronises the line, finds the
// start edge, samples each bit at its centre and reports a byte or a framing
// error through single-cycle registered strobes.
`timescale 1ns / 1ps

module uart_rx_ctrl #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk_50M,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] read_value,
    output logic                 read_complete,
    output logic                 read_error,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] value_q, value_d;
    logic                 complete_q, complete_d;
    logic                 error_q, error_d;
    logic                 tick_clear;
    logic                 s_tick;

    uart_rx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk_50M),
        .reset  (reset),
        .clear  (tick_clear),
        .s_tick (s_tick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            value_q    <= '0;
            complete_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            value_q    <= value_d;
            complete_q <= complete_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: sample at mid start bit, then once per bit period.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        value_d    = value_q;
        complete_d = 1'b0;
        error_d    = 1'b0;
        tick_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d    = StStart;
                    tcnt_d     = '0;
                    bcnt_d     = '0;
                    tick_clear = 1'b1;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (tcnt_q == HALF_LAST) begin
                        tcnt_d  = '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bcnt_d  = bcnt_q + BW'(1);
                        if (bcnt_q == BIT_LAST) begin
                            state_d = StStop;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (tcnt_q == FULL_LAST) begin
                        tcnt_d = '0;
                        if (rx_s_q) begin
                            value_d    = shreg_q;
                            complete_d = 1'b1;
                            // Leaving at mid stop bit allows a zero idle gap.
                            state_d    = StIdle;
                        end else begin
                            error_d = 1'b1;
                            state_d = StWaitHigh;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            StWaitHigh: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign read_value    = value_q;
    assign read_complete = complete_q;
    assign read_error    = error_q;
    assign busy          = (state_q != StIdle);

endmodule
